gate_sweep_ctrl: RTL
====================

Name: gate_sweep_ctrl

Overview:
Self-test sequencer for the shared 2x4-decoder universal gate block (NAND/NOR outputs). On a start request it drives the gate inputs (a,b) through 00, 01, 10, 11 in that order. It holds each combination for a programmable settle time, then samples g_nand/g_nor into truth-table registers. It compares the result against the expected tables and reports pass/fail with a busy/done handshake. It sits between the gate block and the system-level test control.

Parameters:
HOLD_CYCLES, 2, cycles each input combination is driven before sampling; legal range 1..255
CNT_W, 8, width of the hold counter; must hold HOLD_CYCLES-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  sweep request, sampled only in IDLE
g_nand_i  input  1  NAND output from gate block
g_nor_i  input  1  NOR output from gate block
a_o  output  1  gate input a (registered)
b_o  output  1  gate input b (registered)
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when the sweep completes
nand_tt  output  4  captured NAND table, bit index = {a,b}
nor_tt  output  4  captured NOR table, bit index = {a,b}
pass  output  1  1 when nand_tt==4'b0111 and nor_tt==4'b0001

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state IDLE; a_o=b_o=0; busy=0; done=0; nand_tt=nor_tt=4'b0000; pass=0; idx=0; cnt=0.
- FSM states: IDLE, DRIVE, FINISH.
- IDLE -> DRIVE on start=1 at an edge:
  - set idx=0, cnt=0, busy=1;
  - clear nand_tt, nor_tt and pass.
- DRIVE:
  - {a_o,b_o}=idx throughout.
  - cnt increments each edge while cnt != HOLD_CYCLES-1.
  - At the edge where cnt==HOLD_CYCLES-1: capture nand_tt[idx]<=g_nand_i and nor_tt[idx]<=g_nor_i, then reset cnt=0.
  - If idx==3 at that edge: go to FINISH, set busy=0, set done=1, and compute pass from the final tables including this sample.
  - Otherwise idx<=idx+1.
- FINISH: lasts one cycle with done=1, then returns to IDLE and clears done. a_o/b_o return to 0 on entering IDLE.
- Timing: each combination occupies exactly HOLD_CYCLES cycles. busy is high for 4*HOLD_CYCLES cycles, starting the cycle after the start edge. done rises on the same edge that busy falls.
- start while busy, or in FINISH, is ignored; there is no queuing.
- Results (nand_tt, nor_tt, pass) stay stable from done until the next accepted start.
- idx is 2 bits and never wraps mid-sweep; the sweep terminates at idx 3.
- rst mid-sweep: abort immediately to the reset values above; no done pulse.
- rst and start asserted together: rst wins.

Optional Feature:
Macro GATE_SWEEP_FAILIDX_EN.
- When defined, adds two outputs:
  - fail_valid (1 bit): set at done when pass=0.
  - fail_idx (2 bits): lowest idx whose NAND or NOR capture mismatched the expected table.
- Both are cleared on rst and on each accepted start. They hold until the next start.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package gate_sweep_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_DRIVE=2'd1, ST_FINISH=2'd2;
  - EXP_NAND=4'b0111 and EXP_NOR=4'b0001.
- One sub-module, sweep_hold_cnt: CNT_W-bit counter with clear/enable and a terminal flag at HOLD_CYCLES-1.
- The FSM, capture and compare logic live in gate_sweep_ctrl.

Test Plan:
1. HOLD_CYCLES=2, connected to a correct NAND/NOR gate block, pulse start one cycle:
   - {a_o,b_o} = 00,00,01,01,10,10,11,11;
   - busy high for 8 cycles; done one cycle on the edge busy falls;
   - nand_tt=0111, nor_tt=0001, pass=1.
2. g_nor_i tied 0, sweep run:
   - nor_tt=0000, pass=0;
   - with GATE_SWEEP_FAILIDX_EN: fail_valid=1, fail_idx=0.
3. g_nand_i tied 1:
   - nand_tt=1111, pass=0;
   - with FAILIDX: fail_idx=3.
4. HOLD_CYCLES=1:
   - busy high exactly 4 cycles; done 4 edges after the start edge;
   - start re-asserted during busy and during done is ignored, with no second sweep.
5. rst asserted in the cycle with idx=2:
   - next cycle all outputs are at reset values, busy=0, no done pulse;
   - a following start runs a full clean sweep with pass=1.
6. Back-to-back runs: start one cycle after the FINISH->IDLE transition is accepted; tables clear at the accept edge and refill correctly.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep self-test: FSM encoding, expected
// NAND/NOR truth tables and a lowest-set-bit helper for failure reporting.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Truth tables indexed by {a,b}
  localparam logic [3:0] EXP_NAND = 4'b0111;
  localparam logic [3:0] EXP_NOR  = 4'b0001;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    if (v[0])      lowest_set = 2'd0;
    else if (v[1]) lowest_set = 2'd1;
    else if (v[2]) lowest_set = 2'd2;
    else           lowest_set = 2'd3;
  endfunction

endpackage

// File: rtl/sweep_hold_cnt.sv
// Hold counter for the gate sweep: counts 0..HOLD_CYCLES-1 while enabled,
// flags the terminal count and wraps to zero on it.
module sweep_hold_cnt #(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_term = (r_cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_term ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer sweeping {a,b} through 00..11 on the NAND/NOR gate block.
// Optional failure index reporting is enabled with `define GATE_SWEEP_FAILIDX_EN.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       g_nand_i,
  input  logic       g_nor_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy,
  output logic       done,
  output logic [3:0] nand_tt,
  output logic [3:0] nor_tt,
  output logic       pass,
`ifdef GATE_SWEEP_FAILIDX_EN
  output logic       fail_valid,
  output logic [1:0] fail_idx,
`endif
  output state_t     dbg_state
);

  state_t     r_state;
  logic [1:0] r_idx;
  logic       r_a, r_b, r_busy, r_done, r_pass;
  logic [3:0] r_nand, r_nor;
  logic [3:0] w_nand_next, w_nor_next;
  logic       w_term;

  sweep_hold_cnt #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state != ST_DRIVE),
    .i_en  (r_state == ST_DRIVE),
    .o_term(w_term)
  );

  // Tables as they will look after the current sample is written in
  always_comb begin
    w_nand_next        = r_nand;
    w_nor_next         = r_nor;
    w_nand_next[r_idx] = g_nand_i;
    w_nor_next[r_idx]  = g_nor_i;
  end

`ifdef GATE_SWEEP_FAILIDX_EN
  logic       r_fail_valid;
  logic [1:0] r_fail_idx;
  logic [3:0] w_mis;

  assign w_mis      = (w_nand_next ^ EXP_NAND) | (w_nor_next ^ EXP_NOR);
  assign fail_valid = r_fail_valid;
  assign fail_idx   = r_fail_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fail_valid <= 1'b0;
      r_fail_idx   <= 2'd0;
    end else if (r_state == ST_IDLE && start) begin
      r_fail_valid <= 1'b0;
      r_fail_idx   <= 2'd0;
    end else if (r_state == ST_DRIVE && w_term && r_idx == 2'd3) begin
      r_fail_valid <= |w_mis;
      r_fail_idx   <= (|w_mis) ? lowest_set(w_mis) : 2'd0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_nand  <= 4'b0000;
      r_nor   <= 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_a    <= 1'b0;
          r_b    <= 1'b0;
          if (start) begin
            r_state <= ST_DRIVE;
            r_idx   <= 2'd0;
            r_busy  <= 1'b1;
            r_nand  <= 4'b0000;
            r_nor   <= 4'b0000;
            r_pass  <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (w_term) begin
            r_nand <= w_nand_next;
            r_nor  <= w_nor_next;
            if (r_idx == 2'd3) begin
              r_state <= ST_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_nand_next == EXP_NAND) && (w_nor_next == EXP_NOR);
            end else begin
              r_idx      <= r_idx + 2'd1;
              {r_a, r_b} <= r_idx + 2'd1;
            end
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_a     <= 1'b0;
          r_b     <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign a_o       = r_a;
  assign b_o       = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign nand_tt   = r_nand;
  assign nor_tt    = r_nor;
  assign pass      = r_pass;
  assign dbg_state = r_state;

endmodule
